// File: rtl/mem_sram_stage_if.sv
// Pipeline-side request/response bundle for the memory-access stage.
// The master is EXE_reg/MEM_reg; the slave is mem_sram_stage.
interface mem_sram_stage_if;
    logic        MEM_R_en;
    logic        MEM_W_en;
    logic [31:0] ALU_result;
    logic [31:0] Val_Rm;
    logic [31:0] Mem_read_value;
    logic        ready;

    modport master (
        output MEM_R_en, MEM_W_en, ALU_result, Val_Rm,
        input  Mem_read_value, ready
    );

    modport slave (
        input  MEM_R_en, MEM_W_en, ALU_result, Val_Rm,
        output Mem_read_value, ready
    );
endinterface

// File: rtl/mem_sram_stage.sv
// Memory-access stage: runs LDR/STR against a 16-bit async SRAM as two
// timed halfword accesses, freezing the pipeline through ready while busy.
module mem_sram_stage #(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned ADDR_OFFSET = 1024
) (
    input  logic               clk,
    input  logic               rst,
    mem_sram_stage_if.slave    bus,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [17:0]        SRAM_ADDR,
    output logic               SRAM_WE_N
);
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned WADDR_W = 17;
    localparam int unsigned ADDR_W  = 18;
    localparam int unsigned HALF_W  = 16;
    localparam int unsigned WORD_W  = 32;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WADDR_W-1:0]   waddr_q, waddr_d;
    logic [WORD_W-1:0]    wdata_q, wdata_d;
    logic                 is_write_q, is_write_d;
    logic [WORD_W-1:0]    rdata_q, rdata_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 we_n_q, we_n_d;
    logic                 oe_q, oe_d;
    logic [HALF_W-1:0]    dout_q, dout_d;

    logic                 req_c;
    logic                 req_write_c;
    logic [WADDR_W-1:0]   req_waddr_c;
    logic                 ready_c;

    assign req_c       = bus.MEM_R_en | bus.MEM_W_en;
    // A simultaneous read+write request is treated as a plain read.
    assign req_write_c = bus.MEM_W_en & ~bus.MEM_R_en;
    assign req_waddr_c = WADDR_W'((bus.ALU_result - WORD_W'(ADDR_OFFSET)) >> 2);
    assign ready_c     = ((state_q == IDLE) && !req_c) || (state_q == DONE);

    assign bus.ready          = ready_c;
    assign bus.Mem_read_value = rdata_q;
    assign SRAM_ADDR          = addr_q;
    assign SRAM_WE_N          = we_n_q;
    assign SRAM_DQ            = oe_q ? dout_q : 16'hzzzz;

    // State and SRAM pin registers; pins only move on state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
            addr_q     <= '0;
            we_n_q     <= 1'b1;
            oe_q       <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            we_n_q     <= we_n_d;
            oe_q       <= oe_d;
            dout_q     <= dout_d;
        end
    end

    // Next-state and next-pin-value logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        we_n_d     = we_n_q;
        oe_d       = oe_q;
        dout_d     = dout_q;

        case (state_q)
            IDLE: begin
                if (req_c) begin
                    state_d    = LOW;
                    cnt_d      = '0;
                    waddr_d    = req_waddr_c;
                    wdata_d    = bus.Val_Rm;
                    is_write_d = req_write_c;
                    addr_d     = {req_waddr_c, 1'b0};
                    we_n_d     = ~req_write_c;
                    oe_d       = req_write_c;
                    dout_d     = bus.Val_Rm[15:0];
                end
            end
            LOW: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    if (!is_write_q) begin
                        rdata_d[15:0] = SRAM_DQ;
                    end
                    state_d = HIGH;
                    cnt_d   = '0;
                    addr_d  = {waddr_q, 1'b1};
                    dout_d  = wdata_q[31:16];
                end
            end
            HIGH: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    if (!is_write_q) begin
                        rdata_d[31:16] = SRAM_DQ;
                    end
                    state_d = DONE;
                    cnt_d   = '0;
                    we_n_d  = 1'b1;
                    oe_d    = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_sram_stage.sv
// Directed bench for mem_sram_stage with a behavioural async SRAM model
// that commits a halfword when its write pulse or address ends (not on reset).
module tb_mem_sram_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_sram_stage_if bus ();
    mem_sram_stage_if bus2 ();

    wire  [15:0] sram_dq;
    wire  [15:0] sram_dq2;
    logic [17:0] sram_addr;
    logic [17:0] sram_addr2;
    logic        sram_we_n;
    logic        sram_we_n2;

    logic        model_en = 1'b0;
    logic [15:0] mem [0:262143];
    logic        pend_v = 1'b0;
    logic [17:0] pend_a = '0;
    logic [15:0] pend_d = '0;

    int checks = 0;
    int errors = 0;

    mem_sram_stage #(.WAIT_CYCLES(5), .ADDR_OFFSET(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (sram_we_n)
    );

    mem_sram_stage #(.WAIT_CYCLES(1), .ADDR_OFFSET(1024)) dut_w1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus2),
        .SRAM_DQ   (sram_dq2),
        .SRAM_ADDR (sram_addr2),
        .SRAM_WE_N (sram_we_n2)
    );

    // Released bus reads as all ones.
    pullup pu_dq (sram_dq);
    pullup pu_dq2 (sram_dq2);

    assign sram_dq = (model_en && sram_we_n) ? mem[sram_addr] : 16'hzzzz;

    always @(negedge clk) begin
        if (pend_v && (sram_we_n || (sram_addr != pend_a))) begin
            if (!rst) mem[pend_a] <= pend_d;
            pend_v <= 1'b0;
        end
        if (!sram_we_n) begin
            pend_v <= 1'b1;
            pend_a <= sram_addr;
            pend_d <= sram_dq;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request and waits until ready; returns at the DONE cycle.
    task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, output int low_cyc,
                              output int we_low, output logic [17:0] fa,
                              output logic [15:0] fd, output logic [17:0] la,
                              output logic [15:0] ld);
        bus.MEM_R_en   = r;
        bus.MEM_W_en   = w;
        bus.ALU_result = a;
        bus.Val_Rm     = d;
        low_cyc = 0;
        we_low  = 0;
        fa = '0; fd = '0; la = '0; ld = '0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (bus.ready) break;
            low_cyc++;
            if (!sram_we_n) begin
                if (we_low == 0) begin
                    fa = sram_addr;
                    fd = sram_dq;
                end
                la = sram_addr;
                ld = sram_dq;
                we_low++;
            end
            tick();
        end
    endtask

    task automatic drop_req();
        bus.MEM_R_en   = 1'b0;
        bus.MEM_W_en   = 1'b0;
        bus.ALU_result = '0;
        bus.Val_Rm     = '0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.ready !== 1'b1 || sram_we_n !== 1'b1 || sram_addr !== 18'd0 ||
            bus.Mem_read_value !== 32'd0 || sram_dq !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_state got ready=%b we_n=%b addr=%0d rd=%h dq=%h exp 1 1 0 00000000 ffff",
                     bus.ready, sram_we_n, sram_addr, bus.Mem_read_value, sram_dq);
        end
        tick();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (bus.ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq !== 16'hFFFF ||
                bus.Mem_read_value !== 32'd0 || sram_addr !== 18'd0) begin
                errors++;
                $display("FAIL idle_cycle%0d got ready=%b we_n=%b dq=%h rd=%h addr=%0d exp 1 1 ffff 0 0",
                         i, bus.ready, sram_we_n, sram_dq, bus.Mem_read_value, sram_addr);
            end
            tick();
        end
    endtask

    task automatic test_store();
        int lc, wl;
        logic [17:0] fa, la;
        logic [15:0] fd, ld;
        run_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, lc, wl, fa, fd, la, ld);
        checks++;
        if (lc != 11 || wl != 10) begin
            errors++;
            $display("FAIL store_latency got ready_low=%0d we_low=%0d exp 11 10", lc, wl);
        end
        checks++;
        if (fa !== 18'd2 || fd !== 16'hBEEF || la !== 18'd3 || ld !== 16'hDEAD) begin
            errors++;
            $display("FAIL store_bus got %0d:%h %0d:%h exp 2:beef 3:dead", fa, fd, la, ld);
        end
        tick();
        drop_req();
        #1;
        checks++;
        if (bus.ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq !== 16'hFFFF ||
            sram_addr !== 18'd0 || bus.Mem_read_value !== 32'd0) begin
            errors++;
            $display("FAIL store_after got ready=%b we_n=%b dq=%h addr=%0d rd=%h exp 1 1 ffff 0 0",
                     bus.ready, sram_we_n, sram_dq, sram_addr, bus.Mem_read_value);
        end
        checks++;
        if (mem[2] !== 16'hBEEF || mem[3] !== 16'hDEAD) begin
            errors++;
            $display("FAIL store_mem got %h %h exp beef dead", mem[2], mem[3]);
        end
        tick();
    endtask

    task automatic test_load();
        int lc, wl;
        logic [17:0] fa, la;
        logic [15:0] fd, ld;
        model_en = 1'b1;
        run_access(1'b1, 1'b0, 32'd1028, 32'h0, lc, wl, fa, fd, la, ld);
        checks++;
        if (lc != 11 || wl != 0) begin
            errors++;
            $display("FAIL load_latency got ready_low=%0d we_low=%0d exp 11 0", lc, wl);
        end
        checks++;
        if (bus.Mem_read_value !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_value got %h exp deadbeef", bus.Mem_read_value);
        end
        tick();
        drop_req();
        model_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.Mem_read_value !== 32'hDEADBEEF || bus.ready !== 1'b1) begin
                errors++;
                $display("FAIL load_hold%0d got rd=%h ready=%b exp deadbeef 1",
                         i, bus.Mem_read_value, bus.ready);
            end
            tick();
        end
    endtask

    task automatic test_both_enables();
        int lc, wl;
        logic [17:0] fa, la;
        logic [15:0] fd, ld;
        run_access(1'b0, 1'b1, 32'd1024, 32'h12345678, lc, wl, fa, fd, la, ld);
        tick();
        drop_req();
        tick();
        checks++;
        if (mem[0] !== 16'h5678 || mem[1] !== 16'h1234) begin
            errors++;
            $display("FAIL both_preload got %h %h exp 5678 1234", mem[0], mem[1]);
        end
        model_en = 1'b1;
        run_access(1'b1, 1'b1, 32'd1024, 32'hFFFF0000, lc, wl, fa, fd, la, ld);
        checks++;
        if (bus.Mem_read_value !== 32'h12345678 || wl != 0 || lc != 11) begin
            errors++;
            $display("FAIL both_read got rd=%h we_low=%0d ready_low=%0d exp 12345678 0 11",
                     bus.Mem_read_value, wl, lc);
        end
        tick();
        drop_req();
        model_en = 1'b0;
        tick();
        checks++;
        if (mem[0] !== 16'h5678 || mem[1] !== 16'h1234) begin
            errors++;
            $display("FAIL both_no_write got %h %h exp 5678 1234", mem[0], mem[1]);
        end
    endtask

    task automatic test_reset_mid_store();
        bus.MEM_W_en   = 1'b1;
        bus.ALU_result = 32'd1024;
        bus.Val_Rm     = 32'hAAAA5555;
        repeat (7) tick();
        checks++;
        if (sram_we_n !== 1'b0 || sram_addr !== 18'd1 || sram_dq !== 16'hAAAA) begin
            errors++;
            $display("FAIL rst_in_high got we_n=%b addr=%0d dq=%h exp 0 1 aaaa",
                     sram_we_n, sram_addr, sram_dq);
        end
        rst = 1'b1;
        drop_req();
        tick();
        #1;
        checks++;
        if (bus.ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq !== 16'hFFFF ||
            bus.Mem_read_value !== 32'd0 || sram_addr !== 18'd0) begin
            errors++;
            $display("FAIL rst_after got ready=%b we_n=%b dq=%h rd=%h addr=%0d exp 1 1 ffff 0 0",
                     bus.ready, sram_we_n, sram_dq, bus.Mem_read_value, sram_addr);
        end
        tick();
        rst = 1'b0;
        checks++;
        if (mem[0] !== 16'h5555 || mem[1] !== 16'h1234) begin
            errors++;
            $display("FAIL rst_mem got %h %h exp 5555 1234", mem[0], mem[1]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lc, wl;
        logic [17:0] fa, la;
        logic [15:0] fd, ld;
        model_en = 1'b1;
        run_access(1'b1, 1'b0, 32'd1024, 32'h0, lc, wl, fa, fd, la, ld);
        checks++;
        if (bus.Mem_read_value !== 32'h12345555 || lc != 11) begin
            errors++;
            $display("FAIL b2b_load got rd=%h ready_low=%0d exp 12345555 11",
                     bus.Mem_read_value, lc);
        end
        tick();
        run_access(1'b0, 1'b1, 32'd1032, 32'h0000CAFE, lc, wl, fa, fd, la, ld);
        checks++;
        if (lc != 11 || wl != 10) begin
            errors++;
            $display("FAIL b2b_store_latency got ready_low=%0d we_low=%0d exp 11 10", lc, wl);
        end
        checks++;
        if (fa !== 18'd4 || fd !== 16'hCAFE || la !== 18'd5 || ld !== 16'h0000) begin
            errors++;
            $display("FAIL b2b_store_bus got %0d:%h %0d:%h exp 4:cafe 5:0000", fa, fd, la, ld);
        end
        checks++;
        if (bus.Mem_read_value !== 32'h12345555) begin
            errors++;
            $display("FAIL b2b_rd_kept got %h exp 12345555", bus.Mem_read_value);
        end
        tick();
        drop_req();
        model_en = 1'b0;
        tick();
        checks++;
        if (mem[4] !== 16'hCAFE || mem[5] !== 16'h0000) begin
            errors++;
            $display("FAIL b2b_mem got %h %h exp cafe 0000", mem[4], mem[5]);
        end
    endtask

    task automatic test_wait1();
        int lc, wl;
        logic [17:0] fa, la;
        logic [15:0] fd, ld;
        for (int pass = 0; pass < 2; pass++) begin
            bus2.MEM_R_en   = (pass == 1);
            bus2.MEM_W_en   = (pass == 0);
            bus2.ALU_result = 32'd1028;
            bus2.Val_Rm     = 32'h00C0FFEE;
            lc = 0; wl = 0;
            fa = '0; fd = '0; la = '0; ld = '0;
            for (int i = 0; i < 32; i++) begin
                #1;
                if (bus2.ready) break;
                lc++;
                if (!sram_we_n2) begin
                    if (wl == 0) begin
                        fa = sram_addr2;
                        fd = sram_dq2;
                    end
                    la = sram_addr2;
                    ld = sram_dq2;
                    wl++;
                end
                tick();
            end
            checks++;
            if (lc != 3 || wl != ((pass == 0) ? 2 : 0)) begin
                errors++;
                $display("FAIL w1_latency pass%0d got ready_low=%0d we_low=%0d exp 3 %0d",
                         pass, lc, wl, (pass == 0) ? 2 : 0);
            end
            if (pass == 0) begin
                checks++;
                if (fa !== 18'd2 || fd !== 16'hFFEE || la !== 18'd3 || ld !== 16'h00C0) begin
                    errors++;
                    $display("FAIL w1_store_bus got %0d:%h %0d:%h exp 2:ffee 3:00c0",
                             fa, fd, la, ld);
                end
            end else begin
                checks++;
                if (bus2.Mem_read_value !== 32'hFFFFFFFF) begin
                    errors++;
                    $display("FAIL w1_load got %h exp ffffffff", bus2.Mem_read_value);
                end
            end
            tick();
            bus2.MEM_R_en = 1'b0;
            bus2.MEM_W_en = 1'b0;
            tick();
        end
    endtask

    initial begin
        drop_req();
        bus2.MEM_R_en   = 1'b0;
        bus2.MEM_W_en   = 1'b0;
        bus2.ALU_result = '0;
        bus2.Val_Rm     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_idle();
        test_store();
        test_load();
        test_both_enables();
        test_reset_mid_store();
        test_back_to_back();
        test_wait1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_sram_stage.md
Name: mem_sram_stage

Overview:
- Memory-access stage of the 5-stage ARM pipeline, between EXE_reg and MEM_reg.
- Executes LDR/STR against the board's external 16-bit asynchronous SRAM. Each 32-bit word is accessed as two 16-bit halves.
- Produces Mem_read_value for MEM_reg.
- Drives ready low while an access is in flight; the hazard/freeze logic uses ready to stall every pipeline register.

Parameters:
- WAIT_CYCLES, 5: clock cycles each 16-bit SRAM access is held. Legal range 1..15.
- ADDR_OFFSET, 1024: byte address mapped to SRAM word 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- MEM_R_en  in  1  load request from EXE_reg
- MEM_W_en  in  1  store request from EXE_reg
- ALU_result  in  32  byte address
- Val_Rm  in  32  store data
- Mem_read_value  out  32  loaded word, to MEM_reg
- ready  out  1  1 = stage may advance; 0 = freeze pipeline
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  out  18  SRAM halfword address
- SRAM_WE_N  out  1  SRAM write enable, active low

Behaviour:
- Reset values and reset mid-operation:
  - rst has priority over everything and acts at the clock edge.
  - state=IDLE, counter=0, Mem_read_value=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ=Z.
  - A reset mid-access abandons the access. A partially completed store leaves the low half written; this is accepted.
- Request and capture:
  - req = MEM_R_en | MEM_W_en.
  - If both enables are high, the access is a read and no write is issued.
  - In IDLE with req=1, register at the clock edge: word address waddr = (ALU_result - ADDR_OFFSET) >> 2, truncated to 17 bits (wraps modulo 2^17); wdata = Val_Rm; the is_write flag.
  - Request inputs are sampled only in IDLE.
- ready (combinational):
  - 1 when (state==IDLE and req==0) or state==DONE.
  - 0 otherwise, including the IDLE cycle in which a request first appears.
- States:
  - IDLE:
    - req=1: go to LOW, counter=0.
    - req=0: stay in IDLE.
  - LOW:
    - SRAM_ADDR = {waddr,1'b0}.
    - Write: SRAM_WE_N=0, SRAM_DQ=wdata[15:0]. Read: SRAM_WE_N=1, SRAM_DQ=Z.
    - Counter increments each cycle.
    - When counter==WAIT_CYCLES-1: on a read, capture SRAM_DQ into Mem_read_value[15:0]; then go to HIGH with counter=0.
  - HIGH:
    - Same as LOW, with SRAM_ADDR = {waddr,1'b1} and data half [31:16].
    - Capture into Mem_read_value[31:16] on a read.
    - Then go to DONE.
  - DONE:
    - ready=1, SRAM_WE_N=1, SRAM_DQ=Z, SRAM_ADDR held.
    - Request inputs are ignored; they belong to the completing instruction, which advances this cycle.
    - Unconditionally go to IDLE.
- Latency:
  - Request seen in cycle 0.
  - ready=0 for cycles 0..2*WAIT_CYCLES (11 cycles at default).
  - ready=1 in cycle 2*WAIT_CYCLES+1.
  - Mem_read_value holds the full new word from that DONE cycle onward.
- Mem_read_value:
  - Changes only on read captures; stores never alter it.
  - Holds between accesses.
- Between accesses:
  - SRAM_DQ is driven only in LOW/HIGH of a write; Z otherwise.
  - SRAM_WE_N changes only on state transitions, so it is glitch-free at the clock edge.
  - SRAM_ADDR is 0 in IDLE.
- Back-to-back requests: a new request is accepted at the earliest in the IDLE cycle following DONE. There is no gap beyond that one IDLE cycle.

Test Plan:
- Idle, no request, 20 cycles -> ready=1 throughout, SRAM_WE_N=1, SRAM_DQ=Z, Mem_read_value=0.
- Store: MEM_W_en=1, ALU_result=1028, Val_Rm=0xDEADBEEF, held until ready -> SRAM model gets addr 2=0xBEEF, addr 3=0xDEAD. ready low exactly 11 cycles, then 1 for one cycle.
- Load of the same address: MEM_R_en=1, ALU_result=1028 -> Mem_read_value=0xDEADBEEF in the DONE cycle. SRAM_WE_N stays 1 for the whole access. The value holds through the following idle cycles.
- Both enables high, address 1024, SRAM words 0/1 preloaded 0x5678/0x1234 -> read performed, Mem_read_value=0x12345678, no write pulse observed.
- rst asserted during HIGH of a store -> next cycle state=IDLE, ready=1 (req low), SRAM_WE_N=1, DQ=Z, Mem_read_value=0. SRAM addr 0 has the low half written, addr 1 is unchanged.
- Back-to-back: load 1024, then store 1032=0x0000CAFE presented in the cycle after DONE -> second access starts immediately, ready low another 11 cycles. Check address mapping 1032 -> SRAM addr 4/5. WAIT_CYCLES=1 variant: ready low 3 cycles.
